// File: rtl/tstamp_clock.sv
// ============================================================================
// Module   : tstamp_clock
// Purpose  : Free-running seconds/nanoseconds time-of-day counter. Each clock
//            it advances by INC_NS_INT ns plus a fixed-point fraction
//            (INC_NS_FRAC / 2^INC_FRAC_BITS ns), so any core clock frequency
//            can be served without a divider. Supports an atomic time load,
//            an optional signed phase adjustment and NUM_CAP independent
//            capture channels with valid/ack handshakes.
// Macro    : TSTAMP_ADJ_EN - when defined, builds the signed phase-adjust
//            path. When undefined, adj_valid/adj_ns are ignored.
// Ports    : clk, reset_n        - core clock, synchronous active-low reset
//            seconds/nanoseconds - current time (registered)
//            set_valid/set_sec/set_ns, set_err - time load, reject pulse
//            adj_valid/adj_ns    - signed phase adjustment
//            cap_trig/cap_ack    - per-channel capture strobe / acknowledge
//            cap_valid/cap_ovf   - per-channel held / dropped-trigger flags
//            cap_sec/cap_ns      - captured time, channel i at [32i+31:32i]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tstamp_clock #(
  parameter int unsigned INC_NS_INT    = 20,
  parameter int unsigned INC_FRAC_BITS = 16,
  parameter int unsigned INC_NS_FRAC   = 0,
  parameter int unsigned NS_PER_SEC    = 1_000_000_000,
  parameter int unsigned NUM_CAP       = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic [31:0]             seconds,
  output logic [31:0]             nanoseconds,
  input  logic                    set_valid,
  input  logic [31:0]             set_sec,
  input  logic [31:0]             set_ns,
  output logic                    set_err,
  input  logic                    adj_valid,
  input  logic [31:0]             adj_ns,
  input  logic [NUM_CAP-1:0]      cap_trig,
  input  logic [NUM_CAP-1:0]      cap_ack,
  output logic [NUM_CAP-1:0]      cap_valid,
  output logic [NUM_CAP-1:0]      cap_ovf,
  output logic [32*NUM_CAP-1:0]   cap_sec,
  output logic [32*NUM_CAP-1:0]   cap_ns
);

  localparam int unsigned        FW       = INC_FRAC_BITS + 1;
  localparam logic signed [33:0] NS_MOD   = 34'(NS_PER_SEC);
  localparam logic [33:0]        NS_MOD_U = 34'(NS_PER_SEC);
  localparam logic signed [33:0] NS_INC   = 34'(INC_NS_INT);
  localparam logic [FW-1:0]      FRAC_INC = FW'(INC_NS_FRAC);

  logic [31:0]              sec_q, sec_d;
  logic [31:0]              ns_q, ns_d;
  logic [INC_FRAC_BITS-1:0] frac_q, frac_d;
  logic                     set_err_q, set_err_d;
  logic [NUM_CAP-1:0]       cap_valid_q, cap_valid_d;
  logic [NUM_CAP-1:0]       cap_ovf_q, cap_ovf_d;
  logic [32*NUM_CAP-1:0]    cap_sec_q, cap_sec_d;
  logic [32*NUM_CAP-1:0]    cap_ns_q, cap_ns_d;

  logic [FW-1:0]            frac_sum;
  logic signed [33:0]       ns_raw;
  logic signed [33:0]       ns_norm;
  logic [31:0]              sec_norm;
  logic                     set_ok;
  logic                     unused_bits;

  // Time update: increment with fractional carry, optional adjust,
  // normalise into [0, NS_PER_SEC), then let an accepted load override.
  always_comb begin
    frac_sum = {1'b0, frac_q} + FRAC_INC;
    ns_raw   = $signed({2'b00, ns_q}) + NS_INC
             + $signed({33'd0, frac_sum[INC_FRAC_BITS]});
`ifdef TSTAMP_ADJ_EN
    // A same-cycle load always wins, so the adjustment is dropped then,
    // even when the load itself is rejected.
    if (adj_valid && !set_valid) begin
      ns_raw = ns_raw + $signed({{2{adj_ns[31]}}, adj_ns});
    end
`endif

    // The remainder past the rollover is kept so no time is lost.
    sec_norm = sec_q;
    ns_norm  = ns_raw;
    if (ns_raw >= NS_MOD) begin
      ns_norm  = ns_raw - NS_MOD;
      sec_norm = sec_q + 32'd1;
    end
`ifdef TSTAMP_ADJ_EN
    else if (ns_raw < 34'sd0) begin
      ns_norm  = ns_raw + NS_MOD;
      sec_norm = sec_q - 32'd1;
    end
`endif

    set_ok    = set_valid && ({2'b00, set_ns} < NS_MOD_U);
    set_err_d = set_valid && !set_ok;

    if (set_ok) begin
      sec_d  = set_sec;
      ns_d   = set_ns;
      frac_d = '0;
    end else begin
      sec_d  = sec_norm;
      ns_d   = ns_norm[31:0];
      frac_d = frac_sum[INC_FRAC_BITS-1:0];
    end
  end

  // Capture channels sample the pre-update time, i.e. the value currently
  // on the outputs. A trigger with a same-cycle ack replaces the held value.
  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_ovf_d   = cap_ovf_q;
    cap_sec_d   = cap_sec_q;
    cap_ns_d    = cap_ns_q;
    for (int i = 0; i < int'(NUM_CAP); i++) begin
      if (cap_trig[i]) begin
        if (!cap_valid_q[i] || cap_ack[i]) begin
          cap_sec_d[32*i +: 32] = sec_q;
          cap_ns_d[32*i +: 32]  = ns_q;
          cap_valid_d[i]        = 1'b1;
          cap_ovf_d[i]          = 1'b0;
        end else begin
          cap_ovf_d[i] = 1'b1;
        end
      end else if (cap_ack[i]) begin
        cap_valid_d[i] = 1'b0;
        cap_ovf_d[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_q       <= '0;
      ns_q        <= '0;
      frac_q      <= '0;
      set_err_q   <= 1'b0;
      cap_valid_q <= '0;
      cap_ovf_q   <= '0;
      cap_sec_q   <= '0;
      cap_ns_q    <= '0;
    end else begin
      sec_q       <= sec_d;
      ns_q        <= ns_d;
      frac_q      <= frac_d;
      set_err_q   <= set_err_d;
      cap_valid_q <= cap_valid_d;
      cap_ovf_q   <= cap_ovf_d;
      cap_sec_q   <= cap_sec_d;
      cap_ns_q    <= cap_ns_d;
    end
  end

  // The normalised value always fits in 32 bits; the top bits only carry
  // sign/overflow during normalisation.
`ifdef TSTAMP_ADJ_EN
  assign unused_bits = ^ns_norm[33:32];
`else
  assign unused_bits = ^{ns_norm[33:32], adj_valid, adj_ns};
`endif

  assign seconds     = sec_q;
  assign nanoseconds = ns_q;
  assign set_err     = set_err_q;
  assign cap_valid   = cap_valid_q;
  assign cap_ovf     = cap_ovf_q;
  assign cap_sec     = cap_sec_q;
  assign cap_ns      = cap_ns_q;

endmodule

`default_nettype wire

// File: tb/tb_tstamp_clock.sv
// ============================================================================
// Module   : tb_tstamp_clock
// Purpose  : Self-checking bench for tstamp_clock (NS_PER_SEC=1000, INT=20,
//            FRAC=0.5 ns, 2 capture channels). Directed vector table, hand
//            sequences for reset, plus randomized traffic against a
//            reference model that tracks time as a single fixed-point count.
//            Adjust expectations follow TSTAMP_ADJ_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tstamp_clock;

  localparam longint SCALE = 65536;
  localparam longint NS    = 1000;
  localparam longint INT   = 20;
  localparam longint FRAC  = 32768;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] seconds, nanoseconds;
  logic        set_valid;
  logic [31:0] set_sec, set_ns;
  logic        set_err;
  logic        adj_valid;
  logic [31:0] adj_ns;
  logic [1:0]  cap_trig, cap_ack, cap_valid, cap_ovf;
  logic [63:0] cap_sec, cap_ns;

  int n_tests = 0;
  int n_fail  = 0;

  tstamp_clock #(
    .INC_NS_INT(20), .INC_FRAC_BITS(16), .INC_NS_FRAC(32768),
    .NS_PER_SEC(1000), .NUM_CAP(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .seconds(seconds), .nanoseconds(nanoseconds),
    .set_valid(set_valid), .set_sec(set_sec), .set_ns(set_ns),
    .set_err(set_err),
    .adj_valid(adj_valid), .adj_ns(adj_ns),
    .cap_trig(cap_trig), .cap_ack(cap_ack),
    .cap_valid(cap_valid), .cap_ovf(cap_ovf),
    .cap_sec(cap_sec), .cap_ns(cap_ns)
  );

  always #5 clk = ~clk;

  // Reference model: time is one fixed-point count t = ns*2^16 + frac.
  logic [31:0] m_sec, m_ns;
  longint      m_frac;
  logic        m_err;
  logic [1:0]  m_cv, m_ovf;
  logic [31:0] m_csec [2];
  logic [31:0] m_cns  [2];

  task automatic model_edge();
    longint t;
    if (!reset_n) begin
      m_sec = 0; m_ns = 0; m_frac = 0; m_err = 0; m_cv = 0; m_ovf = 0;
      for (int i = 0; i < 2; i++) begin m_csec[i] = 0; m_cns[i] = 0; end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (cap_trig[i]) begin
        if (!m_cv[i] || cap_ack[i]) begin
          m_csec[i] = m_sec; m_cns[i] = m_ns; m_cv[i] = 1'b1; m_ovf[i] = 1'b0;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end else if (cap_ack[i]) begin
        m_cv[i] = 1'b0; m_ovf[i] = 1'b0;
      end
    end
    m_err = 1'b0;
    if (set_valid && longint'(set_ns) < NS) begin
      m_sec = set_sec; m_ns = set_ns; m_frac = 0;
    end else begin
      if (set_valid) m_err = 1'b1;
      t = longint'(m_ns) * SCALE + m_frac + INT * SCALE + FRAC;
`ifdef TSTAMP_ADJ_EN
      if (adj_valid && !set_valid) t = t + longint'($signed(adj_ns)) * SCALE;
`endif
      if (t >= NS * SCALE) begin
        t = t - NS * SCALE; m_sec = m_sec + 32'd1;
      end else if (t < 0) begin
        t = t + NS * SCALE; m_sec = m_sec - 32'd1;
      end
      m_ns   = 32'(t / SCALE);
      m_frac = t % SCALE;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    check("seconds", 64'(seconds), 64'(m_sec));
    check("nanoseconds", 64'(nanoseconds), 64'(m_ns));
    check("set_err", 64'(set_err), 64'(m_err));
    check("cap_valid", 64'(cap_valid), 64'(m_cv));
    check("cap_ovf", 64'(cap_ovf), 64'(m_ovf));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cap_sec[%0d]", i), 64'(cap_sec[32*i +: 32]), 64'(m_csec[i]));
      check($sformatf("cap_ns[%0d]", i), 64'(cap_ns[32*i +: 32]), 64'(m_cns[i]));
    end
  endtask

  // Advance one clock: update the model from the inputs sampled at this
  // edge, then compare shortly after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    set_valid = 0; set_sec = 0; set_ns = 0;
    adj_valid = 0; adj_ns = 0; cap_trig = 0; cap_ack = 0;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] ss, sn;
    logic        av;
    logic [31:0] an;
    logic [1:0]  tr, ak;
    logic [31:0] e_sec, e_ns;
    logic        e_err;
    logic [1:0]  e_cv, e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [31:0] ss, input logic [31:0] sn,
                     input logic av, input int an, input logic [1:0] tr,
                     input logic [1:0] ak, input logic [31:0] es, input logic [31:0] en,
                     input logic ee, input logic [1:0] ecv, input logic [1:0] eovf);
    vec_t v;
    v.sv = sv; v.ss = ss; v.sn = sn; v.av = av; v.an = 32'(an);
    v.tr = tr; v.ak = ak; v.e_sec = es; v.e_ns = en; v.e_err = ee;
    v.e_cv = ecv; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;

    // Reset state, then first count from reset.
    step();
    check("reset seconds", 64'(seconds), 64'd0);
    check("reset ns", 64'(nanoseconds), 64'd0);
    reset_n = 1'b1;
    step();
    check("first count ns", 64'(nanoseconds), 64'd20);

    // Directed vectors: load, reject, capture handshake, adjust, rollover.
    add(1, 5, 999,  0, 0,   2'b00, 2'b11, 5, 999, 0, 2'b00, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 6, 19,  0, 2'b00, 2'b00);
    add(1, 9, 1000, 0, 0,   2'b00, 2'b00, 6, 40,  1, 2'b00, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 6, 60,  0, 2'b00, 2'b00);
    add(1, 7, 400,  0, 0,   2'b00, 2'b00, 7, 400, 0, 2'b00, 2'b00);
    add(0, 0, 0,    0, 0,   2'b01, 2'b00, 7, 420, 0, 2'b01, 2'b00);
    add(0, 0, 0,    0, 0,   2'b01, 2'b00, 7, 441, 0, 2'b01, 2'b01);
    add(0, 0, 0,    0, 0,   2'b00, 2'b01, 7, 461, 0, 2'b00, 2'b00);
    add(0, 0, 0,    0, 0,   2'b10, 2'b00, 7, 482, 0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b10, 2'b10, 7, 502, 0, 2'b10, 2'b00);
    add(1, 3, 10,   0, 0,   2'b00, 2'b00, 3, 10,  0, 2'b10, 2'b00);
`ifdef TSTAMP_ADJ_EN
    add(0, 0, 0,    1, -50, 2'b00, 2'b00, 2, 980, 0, 2'b10, 2'b00);
`else
    add(0, 0, 0,    1, -50, 2'b00, 2'b00, 3, 30,  0, 2'b10, 2'b00);
`endif
    add(1, 8, 100,  1, -50, 2'b00, 2'b00, 8, 100, 0, 2'b10, 2'b00);
`ifdef TSTAMP_ADJ_EN
    add(0, 0, 0,    1, 500, 2'b00, 2'b00, 8, 620, 0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 8, 641, 0, 2'b10, 2'b00);
`else
    add(0, 0, 0,    1, 500, 2'b00, 2'b00, 8, 120, 0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 8, 141, 0, 2'b10, 2'b00);
`endif
    add(1, 0, 960,  0, 0,   2'b00, 2'b00, 0, 960, 0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 0, 980, 0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 1, 1,   0, 2'b10, 2'b00);
    add(0, 0, 0,    0, 0,   2'b00, 2'b00, 1, 21,  0, 2'b10, 2'b00);

    for (int k = 0; k < vecs.size(); k++) begin
      set_valid = vecs[k].sv; set_sec = vecs[k].ss; set_ns = vecs[k].sn;
      adj_valid = vecs[k].av; adj_ns = vecs[k].an;
      cap_trig = vecs[k].tr; cap_ack = vecs[k].ak;
      step();
      check($sformatf("vec%0d sec", k), 64'(seconds), 64'(vecs[k].e_sec));
      check($sformatf("vec%0d ns", k), 64'(nanoseconds), 64'(vecs[k].e_ns));
      check($sformatf("vec%0d set_err", k), 64'(set_err), 64'(vecs[k].e_err));
      check($sformatf("vec%0d cap_valid", k), 64'(cap_valid), 64'(vecs[k].e_cv));
      check($sformatf("vec%0d cap_ovf", k), 64'(cap_ovf), 64'(vecs[k].e_ovf));
    end
    // Channel 0 captured 7/400, channel 1 re-captured 7/482 on trig+ack.
    check("cap0 ns held", 64'(cap_ns[31:0]), 64'd400);
    check("cap1 ns replaced", 64'(cap_ns[63:32]), 64'd482);
    idle_inputs();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      set_valid = ($urandom_range(0, 15) == 0);
      set_sec   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2))
                                              : $urandom_range(0, 3);
      set_ns    = $urandom_range(0, 1100);
      adj_valid = ($urandom_range(0, 5) == 0);
      adj_ns    = 32'($signed($urandom_range(0, 1956)) - 978);
      cap_trig  = 2'($urandom_range(0, 3));
      cap_ack   = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();

    // Reset mid-operation with captures pending.
    cap_trig = 2'b11;
    step();
    cap_trig = 2'b00;
    reset_n  = 1'b0;
    step();
    check("midreset seconds", 64'(seconds), 64'd0);
    check("midreset ns", 64'(nanoseconds), 64'd0);
    check("midreset cap_valid", 64'(cap_valid), 64'd0);
    check("midreset cap_sec", cap_sec, 64'd0);
    reset_n = 1'b1;
    step();
    check("resume ns", 64'(nanoseconds), 64'd20);
    check("resume sec", 64'(seconds), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
